cache_mem_arbiter: RTL and testbench

Sequences line-sized transfers between the two L1 caches of the RV32I core and the single main-memory port. The instruction cache issues line refills (read-only); the data cache issues line refills and dirty-line writebacks. The block selects one owner per line, drives a word-by-word burst to memory, and routes read data back to the owner. It signals completion so the cache can drop its `miss` stall.

---
 rtl/cache_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache refills and D-cache refills/writebacks onto one word-wide memory port,
// one cache line per grant. Define ARB_ROUND_ROBIN_EN for round-robin instead of D-over-I priority.
module cache_mem_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ic_req,
    input  logic [31:0]      ic_addr,
    output logic [31:0]      ic_rdata,
    output logic             ic_rvalid,
    output logic             ic_done,
    input  logic             dc_req,
    input  logic             dc_we,
    input  logic [31:0]      dc_addr,
    input  logic [31:0]      dc_wdata,
    output logic [OFF_W-1:0] dc_widx,
    output logic [31:0]      dc_rdata,
    output logic             dc_rvalid,
    output logic             dc_done,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic             busy
);
    localparam int TAG_W = 30 - OFF_W;

    typedef enum logic [1:0] {IDLE, IC_XFER, DC_XFER, DONE} state_t;

    state_t           state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] base_q, base_d;
    logic             we_q, we_d;
    // Owner of the current/most recent line; in the round-robin build it is also the last-granted pointer.
    logic             own_dc_q, own_dc_d;
    logic             grant_dc;

    // Byte/word offset bits of the request addresses are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ic_addr[OFF_W+1:0], dc_addr[OFF_W+1:0]};

`ifdef ARB_ROUND_ROBIN_EN
    assign grant_dc = dc_req && (!ic_req || !own_dc_q);
`else
    assign grant_dc = dc_req;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        we_d     = we_q;
        own_dc_d = own_dc_q;
        case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    own_dc_d = grant_dc;
                    cnt_d    = '0;
                    if (grant_dc) begin
                        base_d  = dc_addr[31:OFF_W+2];
                        we_d    = dc_we;
                        state_d = DC_XFER;
                    end else begin
                        base_d  = ic_addr[31:OFF_W+2];
                        we_d    = 1'b0;
                        state_d = IC_XFER;
                    end
                end
            end
            IC_XFER, DC_XFER: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(LINE_WORDS - 1))
                        state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            we_q     <= 1'b0;
            own_dc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            we_q     <= we_d;
            own_dc_q <= own_dc_d;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        dc_widx   = '0;
        ic_rdata  = '0;
        ic_rvalid = 1'b0;
        dc_rdata  = '0;
        dc_rvalid = 1'b0;
        ic_done   = 1'b0;
        dc_done   = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IC_XFER: begin
                mem_req   = 1'b1;
                mem_addr  = {base_q, cnt_q, 2'b00};
                mem_wdata = dc_wdata;
                if (mem_ack) begin
                    ic_rvalid = 1'b1;
                    ic_rdata  = mem_rdata;
                end
            end
            DC_XFER: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {base_q, cnt_q, 2'b00};
                mem_wdata = dc_wdata;
                dc_widx   = cnt_q;
                if (mem_ack && !we_q) begin
                    dc_rvalid = 1'b1;
                    dc_rdata  = mem_rdata;
                end
            end
            DONE: begin
                ic_done = !own_dc_q;
                dc_done = own_dc_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: a line-level model predicts grant order and every
// memory word, rdata word and done pulse; a negedge monitor pops and compares.
module tb_cache_mem_arbiter;
    localparam int LW    = 8;
    localparam int OFF_W = $clog2(LW);
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk, rst;
    logic             ic_req, dc_req, dc_we;
    logic [31:0]      ic_addr, dc_addr, dc_wdata;
    logic [31:0]      ic_rdata, dc_rdata, mem_addr, mem_wdata, mem_rdata;
    logic             ic_rvalid, ic_done, dc_rvalid, dc_done;
    logic [OFF_W-1:0] dc_widx;
    logic             mem_req, mem_we, mem_ack, busy;

    cache_mem_arbiter #(.LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_widx(dc_widx),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          idx;
        bit          dc;
        bit          last;
    } op_t;

    op_t         exp_mem[$];
    logic [31:0] exp_ic[$];
    logic [31:0] exp_dc[$];
    bit          exp_done[$];

    int          n_cmp = 0, n_bad = 0, acks_seen = 0;
    bit          last_d = 1'b0;
    bit          stray = 1'b0;
    int unsigned ack_min = 0, ack_max = 0;
    logic [31:0] wd_base = 32'h0;

    // D-cache writeback data source: presents wd_base + requested word index.
    assign dc_wdata = wd_base + 32'(dc_widx);

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h at %0t", nm, act, $time);
    endtask

    task automatic push_xfer(input bit dc, input bit we, input logic [31:0] addr, input logic [31:0] wb);
        logic [31:0] mask, base;
        op_t e;
        mask = LW * 4 - 1;
        base = addr & ~mask;
        for (int k = 0; k < LW; k++) begin
            e.we    = we;
            e.addr  = base + 32'(4 * k);
            e.wdata = wb + 32'(k);
            e.idx   = k;
            e.dc    = dc;
            e.last  = (k == LW - 1);
            exp_mem.push_back(e);
            if (!we) begin
                if (dc) exp_dc.push_back(rd_word(e.addr));
                else    exp_ic.push_back(rd_word(e.addr));
            end
        end
        exp_done.push_back(dc);
    endtask

    // Memory: acks after a random wait in [ack_min, ack_max] cycles; optional stray acks while idle.
    initial begin
        int unsigned wait_c;
        wait_c = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (wait_c == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_word(mem_addr);
                    wait_c    = $urandom_range(ack_max, ack_min);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    wait_c    = wait_c - 1;
                end
            end else begin
                mem_ack   = stray;
                mem_rdata = $urandom;
                wait_c    = $urandom_range(ack_max, ack_min);
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        op_t e;
        bit  last_ack, prev_last;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            last_ack = 1'b0;
            if (rst) begin
                if (mem_req && mem_ack) begin
                    acks_seen++;
                    if (exp_mem.size() == 0) fail("mem_unexpected", mem_addr);
                    else begin
                        e = exp_mem.pop_front();
                        chk("mem_we", 32'(mem_we), 32'(e.we));
                        chk("mem_addr", mem_addr, e.addr);
                        chk("dc_widx", 32'(dc_widx), e.dc ? 32'(e.idx) : 32'h0);
                        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                        last_ack = e.last;
                    end
                end
                if (!busy) begin
                    chk("idle_mem_req", 32'(mem_req), 0);
                    chk("idle_mem_we", 32'(mem_we), 0);
                    chk("idle_mem_addr", mem_addr, 0);
                    chk("idle_mem_wdata", mem_wdata, 0);
                    chk("idle_dc_widx", 32'(dc_widx), 0);
                end
                if (ic_rvalid) begin
                    if (exp_ic.size() == 0) fail("ic_rvalid_unexpected", ic_rdata);
                    else chk("ic_rdata", ic_rdata, exp_ic.pop_front());
                end
                if (dc_rvalid) begin
                    if (exp_dc.size() == 0) fail("dc_rvalid_unexpected", dc_rdata);
                    else chk("dc_rdata", dc_rdata, exp_dc.pop_front());
                end
                if (ic_done || dc_done) begin
                    chk("done_onehot", 32'(ic_done & dc_done), 0);
                    chk("mem_req_in_done", 32'(mem_req), 0);
                    if (exp_done.size() == 0) fail("done_unexpected", 32'(dc_done));
                    else chk("done_owner", 32'(dc_done), 32'(exp_done.pop_front()));
                end
                if (prev_last) chk("done_timing", 32'(ic_done | dc_done), 1);
            end
            prev_last = last_ack;
        end
    end

    // One arbitration episode: I-cache wants one line, D-cache wants n_d lines back to back
    // (holding dc_req high across its done). Model predicts grant order from the policy.
    task automatic run_scn(input bit do_i, input int n_d, input logic [31:0] ia, input logic [31:0] da,
                           input bit dwe, input logic [31:0] wb, input bit disturb);
        bit pi, pick_d, dist_done;
        int dl, need, got, a0;
        pi = do_i;
        dl = n_d;
        while (pi || dl > 0) begin
            if (pi && dl > 0) pick_d = RR ? !last_d : 1'b1;
            else              pick_d = (dl > 0);
            last_d = pick_d;
            if (pick_d) begin push_xfer(1'b1, dwe, da, wb); dl--; end
            else        begin push_xfer(1'b0, 1'b0, ia, 32'h0); pi = 1'b0; end
        end
        @(negedge clk);
        ic_addr = ia; dc_addr = da; dc_we = dwe; wd_base = wb;
        ic_req = do_i; dc_req = (n_d > 0);
        need = int'(do_i) + n_d;
        got = 0; dl = n_d; a0 = acks_seen; dist_done = 1'b0;
        for (int c = 0; c < 4000 && got < need; c++) begin
            @(negedge clk);
            if (ic_done) begin got++; ic_req = 1'b0; end
            if (dc_done) begin got++; dl--; dc_req = (dl > 0); end
            if (disturb && !dist_done && acks_seen - a0 >= 3) begin
                dc_req = 1'b0; dc_addr = $urandom; dc_we = !dc_we; dist_done = 1'b1;
            end
        end
        if (got < need) fail("scn_timeout", 32'(got));
        ic_req = 1'b0; dc_req = 1'b0;
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_mem.size() + exp_ic.size() + exp_dc.size() + exp_done.size()), 0);
    endtask

    initial begin
        int a0;
        logic [31:0] ia;
        rst = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dones", 32'({ic_done, dc_done}), 0);
        chk("rst_rvalids", 32'({ic_rvalid, dc_rvalid}), 0);
        chk("rst_dc_widx", 32'(dc_widx), 0);
        rst = 1'b1;

        // I refill alone, ack every cycle.
        ack_min = 0; ack_max = 0;
        run_scn(1'b1, 0, 32'h0000_1234, 32'h0, 1'b0, 32'h0, 1'b0);
        // D writeback, ack after 2 wait cycles per word.
        ack_min = 2; ack_max = 2;
        run_scn(1'b0, 1, 32'h0, 32'h0000_0040, 1'b1, 32'h0000_00A0, 1'b0);
        // Simultaneous requests, then contention with D re-requesting after its done.
        ack_min = 0; ack_max = 2;
        run_scn(1'b1, 1, 32'h0000_2000, 32'h0000_3004, 1'b0, 32'h0, 1'b0);
        run_scn(1'b1, 2, 32'h0000_4010, 32'h0000_5020, 1'b1, 32'h1000_0000, 1'b0);
        // Mid-burst disturbance, then stray acks while idle.
        ack_min = 0; ack_max = 1;
        run_scn(1'b0, 1, 32'h0, 32'h0000_7788, 1'b0, 32'h0, 1'b1);
        stray = 1'b1;
        repeat (4) @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        chk("stray_ack_busy", 32'(busy), 0);

        // Reset mid-burst, then the held refill restarts at word 0.
        ia = 32'h0000_9ABC;
        push_xfer(1'b0, 1'b0, ia, 32'h0);
        @(negedge clk);
        ic_addr = ia; ic_req = 1'b1; a0 = acks_seen;
        for (int c = 0; c < 200 && acks_seen - a0 < 4; c++) @(negedge clk);
        if (acks_seen - a0 < 4) fail("rst_burst_timeout", 32'(acks_seen - a0));
        rst = 1'b0;
        @(posedge clk);
        #2;
        exp_mem.delete(); exp_ic.delete(); exp_dc.delete(); exp_done.delete();
        last_d = 1'b0;
        @(negedge clk);
        chk("midrst_mem_req", 32'(mem_req), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'({ic_done, dc_done}), 0);
        push_xfer(1'b0, 1'b0, ia, 32'h0);
        last_d = 1'b0;
        rst = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 400 && !seen; c++) begin
                @(negedge clk);
                if (ic_done) begin seen = 1'b1; ic_req = 1'b0; end
            end
            if (!seen) fail("restart_timeout", 32'h0);
        end
        @(negedge clk);
        chk("restart_drained", 32'(exp_mem.size() + exp_ic.size() + exp_done.size()), 0);

        // Randomized episodes.
        for (int t = 0; t < 24; t++) begin
            bit di;
            int nd;
            di = 1'($urandom);
            nd = int'($urandom_range(2, 0));
            if (!di && nd == 0) nd = 1;
            ack_min = 0; ack_max = $urandom_range(3, 0);
            run_scn(di, nd, $urandom, $urandom, 1'($urandom), $urandom, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
